// File: rtl/bcd_add_sequencer.sv
// Two-digit BCD adder that time-shares one 4-bit binary adder for both digit sums and +6 corrections.
// A valid add takes five cycles from an accepted start to done. An invalid digit reports done one cycle after start.
module bcd_add_sequencer (
  input  logic        clk,
  input  logic        reset,
  input  logic        start,
  input  logic [7:0]  a,
  input  logic [7:0]  b,
  input  logic        cin,
  output logic        busy,
  output logic        done,
  output logic        err,
  output logic [11:0] sum
);

  typedef enum logic [2:0] {
    IDLE = 3'd0,
    ADD0 = 3'd1,
    FIX0 = 3'd2,
    ADD1 = 3'd3,
    FIX1 = 3'd4,
    DONE = 3'd5
  } state_t;

  state_t      state;
  logic [7:0]  a_q;
  logic [7:0]  b_q;
  logic        cin_q;
  logic [4:0]  tmp;
  logic        carry;

  logic [3:0]  add_x;
  logic [3:0]  add_y;
  logic        add_c;
  logic [4:0]  raw;
  logic        digits_ok;
  logic        fix_needed;

  // The only adder in the block. The state selects whether it forms a digit sum or applies the +6 correction.
  always_comb begin
    add_x = 4'd0;
    add_y = 4'd0;
    add_c = 1'b0;
    case (state)
      ADD0: begin
        add_x = a_q[3:0];
        add_y = b_q[3:0];
        add_c = cin_q;
      end
      ADD1: begin
        add_x = a_q[7:4];
        add_y = b_q[7:4];
        add_c = carry;
      end
      FIX0, FIX1: begin
        add_x = tmp[3:0];
        add_y = 4'd6;
        add_c = 1'b0;
      end
      default: begin
        add_x = 4'd0;
        add_y = 4'd0;
        add_c = 1'b0;
      end
    endcase
  end

  assign raw        = {1'b0, add_x} + {1'b0, add_y} + {4'd0, add_c};
  assign digits_ok  = (a[3:0] <= 4'd9) && (a[7:4] <= 4'd9) &&
                      (b[3:0] <= 4'd9) && (b[7:4] <= 4'd9);
  assign fix_needed = (tmp > 5'd9);

  always_ff @(posedge clk) begin
    if (reset) begin
      state <= IDLE;
      a_q   <= 8'h00;
      b_q   <= 8'h00;
      cin_q <= 1'b0;
      tmp   <= 5'd0;
      carry <= 1'b0;
      busy  <= 1'b0;
      done  <= 1'b0;
      err   <= 1'b0;
      sum   <= 12'h000;
    end else begin
      case (state)
        IDLE: begin
          done <= 1'b0;
          if (start) begin
            if (digits_ok) begin
              a_q   <= a;
              b_q   <= b;
              cin_q <= cin;
              err   <= 1'b0;
              busy  <= 1'b1;
              state <= ADD0;
            end else begin
              err   <= 1'b1;
              sum   <= 12'h000;
              done  <= 1'b1;
              state <= DONE;
            end
          end
        end

        ADD0: begin
          tmp   <= raw;
          state <= FIX0;
        end

        FIX0: begin
          if (fix_needed) begin
            sum[3:0] <= raw[3:0];
            carry    <= 1'b1;
          end else begin
            sum[3:0] <= tmp[3:0];
            carry    <= 1'b0;
          end
          state <= ADD1;
        end

        ADD1: begin
          tmp   <= raw;
          state <= FIX1;
        end

        // The carry out of the tens digit becomes the hundreds digit.
        FIX1: begin
          if (fix_needed) begin
            sum[7:4]  <= raw[3:0];
            sum[11:8] <= 4'd1;
            carry     <= 1'b1;
          end else begin
            sum[7:4]  <= tmp[3:0];
            sum[11:8] <= 4'd0;
            carry     <= 1'b0;
          end
          busy  <= 1'b0;
          done  <= 1'b1;
          state <= DONE;
        end

        DONE: begin
          done  <= 1'b0;
          state <= IDLE;
        end

        default: begin
          busy  <= 1'b0;
          done  <= 1'b0;
          state <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_bcd_add_sequencer.sv
// Self-checking bench for bcd_add_sequencer. It uses a vector table, randomized adds checked against a decimal model, and hand-written busy, abort and reset sequences.
module tb_bcd_add_sequencer;

  logic        clk = 1'b0;
  logic        reset;
  logic        start;
  logic [7:0]  a;
  logic [7:0]  b;
  logic        cin;
  logic        busy;
  logic        done;
  logic        err;
  logic [11:0] sum;

  int checks   = 0;
  int failures = 0;

  bcd_add_sequencer dut (
    .clk   (clk),
    .reset (reset),
    .start (start),
    .a     (a),
    .b     (b),
    .cin   (cin),
    .busy  (busy),
    .done  (done),
    .err   (err),
    .sum   (sum)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [7:0]  va;
    logic [7:0]  vb;
    logic        vc;
    logic [11:0] exp_sum;
    logic        exp_err;
    int          exp_lat;
  } vec_t;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // The reference model works on decimal values. Any nibble above 9 makes the whole request an error.
  task automatic model(input logic [7:0] ma, input logic [7:0] mb, input logic mc,
                       output logic [11:0] ms, output logic me);
    int val;
    if (ma[3:0] > 9 || ma[7:4] > 9 || mb[3:0] > 9 || mb[7:4] > 9) begin
      ms = 12'h000;
      me = 1'b1;
    end else begin
      val = int'(ma[7:4]) * 10 + int'(ma[3:0]) + int'(mb[7:4]) * 10 + int'(mb[3:0]) + int'(mc);
      ms  = {4'(val / 100), 4'((val / 10) % 10), 4'(val % 10)};
      me  = 1'b0;
    end
  endtask

  // Called 1 time unit after a rising edge. It returns at the same phase after the add has completed.
  task automatic run_add(input logic [7:0] ta, input logic [7:0] tb_, input logic tc,
                         input logic [11:0] es, input logic ee, input int elat, input string tag);
    int lat;
    lat   = 0;
    a     = ta;
    b     = tb_;
    cin   = tc;
    start = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0;
    a     = 8'($urandom);
    b     = 8'($urandom);
    cin   = 1'($urandom);
    for (int k = 1; k <= 10; k++) begin
      @(negedge clk);
      check({tag, "/busy"}, 32'(busy), 32'(elat == 5 && k < 5));
      if (done) begin
        lat = k;
        break;
      end
    end
    check({tag, "/latency"}, 32'(lat), 32'(elat));
    check({tag, "/sum"}, 32'(sum), 32'(es));
    check({tag, "/err"}, 32'(err), 32'(ee));
    @(negedge clk);
    check({tag, "/done_pulse"}, 32'(done), 32'd0);
    check({tag, "/sum_hold"}, 32'(sum), 32'(es));
    check({tag, "/err_hold"}, 32'(err), 32'(ee));
    @(posedge clk);
    #1;
  endtask

  initial begin
    vec_t        vecs[9];
    logic [7:0]  ra;
    logic [7:0]  rb;
    logic        rc;
    logic [11:0] ms;
    logic        me;
    int          ndone;
    int          lat;
    int          nbusy;

    vecs[0] = '{8'h47, 8'h38, 1'b0, 12'h085, 1'b0, 5};
    vecs[1] = '{8'h99, 8'h99, 1'b1, 12'h199, 1'b0, 5};
    vecs[2] = '{8'h3A, 8'h00, 1'b0, 12'h000, 1'b1, 1};
    vecs[3] = '{8'h05, 8'h05, 1'b0, 12'h010, 1'b0, 5};
    vecs[4] = '{8'h00, 8'h00, 1'b0, 12'h000, 1'b0, 5};
    vecs[5] = '{8'h50, 8'h50, 1'b0, 12'h100, 1'b0, 5};
    vecs[6] = '{8'h09, 8'h00, 1'b1, 12'h010, 1'b0, 5};
    vecs[7] = '{8'h12, 8'hA5, 1'b1, 12'h000, 1'b1, 1};
    vecs[8] = '{8'h99, 8'h00, 1'b1, 12'h100, 1'b0, 5};

    reset = 1'b1;
    start = 1'b0;
    a     = 8'h00;
    b     = 8'h00;
    cin   = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    check("reset/busy", 32'(busy), 32'd0);
    check("reset/done", 32'(done), 32'd0);
    check("reset/err", 32'(err), 32'd0);
    check("reset/sum", 32'(sum), 32'd0);
    reset = 1'b0;
    @(posedge clk);
    #1;

    for (int i = 0; i < 9; i++)
      run_add(vecs[i].va, vecs[i].vb, vecs[i].vc, vecs[i].exp_sum, vecs[i].exp_err,
              vecs[i].exp_lat, $sformatf("vec%0d", i));

    for (int i = 0; i < 40; i++) begin
      ra = 8'($urandom);
      rb = 8'($urandom);
      rc = 1'($urandom);
      if ($urandom_range(0, 3) != 0) begin
        ra = {4'($urandom_range(0, 9)), 4'($urandom_range(0, 9))};
        rb = {4'($urandom_range(0, 9)), 4'($urandom_range(0, 9))};
      end
      model(ra, rb, rc, ms, me);
      run_add(ra, rb, rc, ms, me, me ? 1 : 5, $sformatf("rand%0d", i));
    end

    // A start pulse while busy or in DONE is ignored, and operand changes mid-flight have no effect.
    ndone = 0;
    lat   = 0;
    a     = 8'h28;
    b     = 8'h19;
    cin   = 1'b1;
    start = 1'b1;
    @(posedge clk);
    #1;
    for (int k = 1; k <= 12; k++) begin
      start = (k == 2 || k == 5);
      a     = 8'($urandom);
      b     = 8'($urandom);
      cin   = 1'($urandom);
      @(negedge clk);
      if (done) begin
        ndone++;
        if (ndone == 1) lat = k;
      end
      @(posedge clk);
      #1;
    end
    start = 1'b0;
    model(8'h28, 8'h19, 1'b1, ms, me);
    check("ignore/done_count", 32'(ndone), 32'd1);
    check("ignore/latency", 32'(lat), 32'd5);
    check("ignore/sum", 32'(sum), 32'(ms));
    check("ignore/err", 32'(err), 32'(me));

    // Reset asserted mid-operation aborts the add. It must not produce a done pulse and must clear sum.
    run_add(8'h47, 8'h38, 1'b0, 12'h085, 1'b0, 5, "pre_abort");
    ndone = 0;
    a     = 8'h12;
    b     = 8'h34;
    cin   = 1'b0;
    start = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0;
    for (int k = 1; k <= 2; k++) begin
      @(negedge clk);
      if (done) ndone++;
      @(posedge clk);
      #1;
    end
    reset = 1'b1;
    @(negedge clk);
    if (done) ndone++;
    @(posedge clk);
    #1;
    check("abort/busy", 32'(busy), 32'd0);
    check("abort/done", 32'(done), 32'd0);
    check("abort/sum", 32'(sum), 32'd0);
    check("abort/err", 32'(err), 32'd0);
    reset = 1'b0;
    for (int k = 0; k < 8; k++) begin
      @(negedge clk);
      if (done) ndone++;
    end
    check("abort/no_done", 32'(ndone), 32'd0);
    @(posedge clk);
    #1;

    // Reset wins over a simultaneous start.
    ndone = 0;
    nbusy = 0;
    reset = 1'b1;
    start = 1'b1;
    a     = 8'h11;
    b     = 8'h22;
    @(posedge clk);
    #1;
    reset = 1'b0;
    start = 1'b0;
    for (int k = 0; k < 8; k++) begin
      @(negedge clk);
      if (done) ndone++;
      if (busy) nbusy++;
    end
    check("prio/no_done", 32'(ndone), 32'd0);
    check("prio/no_busy", 32'(nbusy), 32'd0);
    @(posedge clk);
    #1;

    run_add(8'h64, 8'h36, 1'b0, 12'h100, 1'b0, 5, "post");

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
